// File: rtl/wrq_nr2w_1r1w_pkg.sv
// Shared types and constants for the nr2w 1r1w write-request queue.
package wrq_nr2w_1r1w_pkg;

  // Entry fields are sized for the widest supported configuration; narrower
  // instances zero-extend on the way in and slice on the way out.
  localparam int ENT_ADR_W = 32;
  localparam int ENT_DAT_W = 64;

  localparam logic [15:0] COLL_SAT = 16'hFFFF;

  typedef struct packed {
    logic [ENT_ADR_W-1:0] adr;
    logic [ENT_DAT_W-1:0] dat;
  } wrq_entry_t;

endpackage

// File: rtl/wrq_nr2w_1r1w_fifo.sv
// Single-in/single-out queue of DEPTH address+data entries; a push into a full queue is ignored.
module wrq_fifo
  import wrq_nr2w_1r1w_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int BITDPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wrq_entry_t push_ent,
  input  logic       pop,
  output wrq_entry_t pop_ent,
  output logic       full,
  output logic       empty
);

  wrq_entry_t         mem [DEPTH];
  logic [BITDPTH-1:0] wr_ptr;
  logic [BITDPTH-1:0] rd_ptr;
  logic [BITDPTH:0]   cnt;
  logic               do_push;
  logic               do_pop;

  function automatic logic [BITDPTH-1:0] ptr_inc(input logic [BITDPTH-1:0] p);
    return (p == BITDPTH'(DEPTH - 1)) ? '0 : p + BITDPTH'(1);
  endfunction

  assign full    = (cnt == (BITDPTH+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_ent = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + (BITDPTH+1)'(do_push) - (BITDPTH+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ent;
  end

endmodule

// File: rtl/wrq_nr2w_1r1w.sv
// Two-port write-request queue feeding an nr2w 1r1w core; port 1 wins same-address collisions.
module wrq_nr2w_1r1w
  import wrq_nr2w_1r1w_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int NUMADDR = 8192,
  parameter int DEPTH   = 4,
  parameter int BITDPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in_vld,
  output logic [1:0]           in_rdy,
  input  logic [2*BITADDR-1:0] in_adr,
  input  logic [2*WIDTH-1:0]   in_din,
  input  logic                 ready,
  output logic [1:0]           write,
  output logic [2*BITADDR-1:0] wr_adr,
  output logic [2*WIDTH-1:0]   din,
  output logic [15:0]          coll_cnt,
  output logic                 oor_err
);

  localparam logic [BITADDR:0] ADR_LIM = (BITADDR+1)'(NUMADDR);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == COLL_SAT) ? v : v + 16'd1;
  endfunction

  wrq_entry_t           push_ent [2];
  wrq_entry_t           pop_ent  [2];
  logic [1:0]           full;
  logic [1:0]           empty;
  logic [1:0]           acc;
  logic [1:0]           oor;
  logic [1:0]           push;
  logic [1:0]           pop;
  logic                 coll;
  logic [1:0]           vld_p0;
  logic                 rdy_en;
  logic                 unused_ent;

  logic [1:0]           vld_p1;
  logic [2*BITADDR-1:0] adr_p1;
  logic [2*WIDTH-1:0]   din_p1;
  logic [15:0]          coll_cnt_p1;
  logic                 oor_err_p1;

  // Stage p0: acceptance, range check, queueing and pop arbitration
  for (genvar p = 0; p < 2; p++) begin : g_port
    assign in_rdy[p]   = rdy_en & ~full[p];
    assign acc[p]      = in_vld[p] & in_rdy[p];
    assign oor[p]      = acc[p] & ({1'b0, in_adr[p*BITADDR +: BITADDR]} >= ADR_LIM);
    assign push[p]     = acc[p] & ~oor[p];
    assign pop[p]      = ready & ~empty[p];
    assign push_ent[p] = '{adr: ENT_ADR_W'(in_adr[p*BITADDR +: BITADDR]),
                           dat: ENT_DAT_W'(in_din[p*WIDTH +: WIDTH])};

    wrq_fifo #(
      .DEPTH   (DEPTH),
      .BITDPTH (BITDPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[p]),
      .push_ent (push_ent[p]),
      .pop      (pop[p]),
      .pop_ent  (pop_ent[p]),
      .full     (full[p]),
      .empty    (empty[p])
    );
  end

  assign unused_ent = ^{pop_ent[0], pop_ent[1]};

  assign coll   = pop[0] & pop[1] &
                  (pop_ent[0].adr[BITADDR-1:0] == pop_ent[1].adr[BITADDR-1:0]);
  assign vld_p0 = {pop[1], pop[0] & ~coll};

  // Holds in_rdy low through the first edge after reset so in-flight requests are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Stage p1: registered core interface; idle lanes keep their last address/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= '0;
      adr_p1      <= '0;
      din_p1      <= '0;
      coll_cnt_p1 <= '0;
      oor_err_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      for (int p = 0; p < 2; p++) begin
        if (vld_p0[p]) begin
          adr_p1[p*BITADDR +: BITADDR] <= pop_ent[p].adr[BITADDR-1:0];
          din_p1[p*WIDTH +: WIDTH]     <= pop_ent[p].dat[WIDTH-1:0];
        end
      end
      if (coll) coll_cnt_p1 <= sat_inc(coll_cnt_p1);
      oor_err_p1 <= oor_err_p1 | (|oor);
    end
  end

  assign write    = vld_p1;
  assign wr_adr   = adr_p1;
  assign din      = din_p1;
  assign coll_cnt = coll_cnt_p1;
  assign oor_err  = oor_err_p1;

endmodule

// File: tb/tb_wrq_nr2w_1r1w.sv
// Directed bench for wrq_nr2w_1r1w with hand-computed expectations.
module tb_wrq_nr2w_1r1w;

  localparam int W  = 32;
  localparam int BA = 14;
  localparam int NA = 8192;

  logic            clk;
  logic            rst;
  logic [1:0]      in_vld;
  logic [1:0]      in_rdy;
  logic [2*BA-1:0] in_adr;
  logic [2*W-1:0]  in_din;
  logic            ready;
  logic [1:0]      write;
  logic [2*BA-1:0] wr_adr;
  logic [2*W-1:0]  din;
  logic [15:0]     coll_cnt;
  logic            oor_err;

  int vectors     = 0;
  int miscompares = 0;

  wrq_nr2w_1r1w #(
    .WIDTH   (W),
    .BITADDR (BA),
    .NUMADDR (NA),
    .DEPTH   (4),
    .BITDPTH (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_adr   (in_adr),
    .in_din   (in_din),
    .ready    (ready),
    .write    (write),
    .wr_adr   (wr_adr),
    .din      (din),
    .coll_cnt (coll_cnt),
    .oor_err  (oor_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input int adr, input logic [31:0] d);
    in_adr[p*BA +: BA] = BA'(adr);
    in_din[p*W +: W]   = d;
  endtask

  initial begin
    rst    = 1'b1;
    in_vld = 2'b11;
    in_adr = '0;
    in_din = '0;
    ready  = 1'b0;
    #2;
    chk("rst_in_rdy",   64'(in_rdy),   64'h0);
    chk("rst_write",    64'(write),    64'h0);
    chk("rst_wr_adr",   64'(wr_adr),   64'h0);
    chk("rst_din",      64'(din),      64'h0);
    chk("rst_coll_cnt", 64'(coll_cnt), 64'h0);
    chk("rst_oor_err",  64'(oor_err),  64'h0);
    tick();
    rst    = 1'b0;
    in_vld = 2'b00;
    chk("rdy_before_edge", 64'(in_rdy), 64'h0);
    tick();
    chk("rdy_after_edge", 64'(in_rdy), 64'h3);

    // single write on port 0
    ready = 1'b1;
    in_vld = 2'b01;
    drive(0, 5, 32'hA5A5A5A5);
    tick();
    in_vld = 2'b00;
    chk("single_n1_write", 64'(write), 64'h0);
    tick();
    chk("single_write", 64'(write), 64'h1);
    chk("single_adr",   64'(wr_adr[12:0]), 64'd5);
    chk("single_din",   64'(din[31:0]), 64'hA5A5A5A5);
    tick();
    chk("single_idle", 64'(write), 64'h0);
    chk("single_hold", 64'(din[31:0]), 64'hA5A5A5A5);

    // backpressure on port 1, plus a push attempt while full
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 2'b10;
      drive(1, 10 + i, 32'h100 + 32'(i));
      tick();
    end
    chk("bp_full_rdy", 64'(in_rdy), 64'h1);
    chk("bp_no_write", 64'(write),  64'h0);
    drive(1, 14, 32'h104);
    tick();
    chk("bp_still_full", 64'(in_rdy), 64'h1);
    in_vld = 2'b00;
    ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_write", 64'(write), 64'h2);
      chk("bp_adr",   64'(wr_adr[BA +: BA]), 64'(10 + i));
      chk("bp_din",   64'(din[W +: W]), 64'(32'h100 + 32'(i)));
    end
    tick();
    chk("bp_drained", 64'(write), 64'h0);

    // same-address collision: port 1 wins
    in_vld = 2'b11;
    drive(0, 100, 32'd1);
    drive(1, 100, 32'd2);
    tick();
    in_vld = 2'b00;
    tick();
    chk("coll_write", 64'(write), 64'h2);
    chk("coll_din1",  64'(din[W +: W]), 64'd2);
    chk("coll_adr1",  64'(wr_adr[BA +: BA]), 64'd100);
    chk("coll_din0_hold", 64'(din[31:0]), 64'hA5A5A5A5);
    chk("coll_cnt1",  64'(coll_cnt), 64'd1);

    // distinct addresses in the same cycle: both write
    in_vld = 2'b11;
    drive(0, 7, 32'h77);
    drive(1, 8, 32'h88);
    tick();
    in_vld = 2'b00;
    tick();
    chk("dual_write", 64'(write), 64'h3);
    chk("dual_din",   64'(din), {32'h88, 32'h77});
    chk("dual_cnt",   64'(coll_cnt), 64'd1);

    // out-of-range address dropped, last legal address accepted
    in_vld = 2'b01;
    drive(0, 8192, 32'hDEAD);
    tick();
    in_vld = 2'b00;
    chk("oor_flag", 64'(oor_err), 64'h1);
    tick();
    chk("oor_no_write_a", 64'(write), 64'h0);
    tick();
    chk("oor_no_write_b", 64'(write), 64'h0);
    in_vld = 2'b01;
    drive(0, 8191, 32'h1FFF);
    tick();
    in_vld = 2'b00;
    tick();
    chk("max_adr_write", 64'(write), 64'h1);
    chk("max_adr_val",   64'(wr_adr[0 +: BA]), 64'd8191);
    chk("oor_sticky",    64'(oor_err), 64'h1);

    // reset with three entries queued
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 2'b01;
      drive(0, 20 + i, 32'h200 + 32'(i));
      tick();
    end
    in_vld = 2'b00;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy",  64'(in_rdy),   64'h0);
    chk("mid_rst_cnt",  64'(coll_cnt), 64'h0);
    chk("mid_rst_oor",  64'(oor_err),  64'h0);
    chk("mid_rst_wadr", 64'(wr_adr),   64'h0);
    ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", 64'(in_rdy), 64'h3);
    chk("post_rst_w0",  64'(write),  64'h0);
    tick();
    chk("post_rst_w1",  64'(write),  64'h0);
    tick();
    chk("post_rst_w2",  64'(write),  64'h0);

    // collision counter saturation
    in_vld = 2'b11;
    drive(0, 300, 32'h3);
    drive(1, 300, 32'h4);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_stream_write", 64'(write), 64'h2);
    in_vld = 2'b00;
    tick();
    tick();
    chk("sat_fffe", 64'(coll_cnt), 64'hFFFE);
    in_vld = 2'b11;
    tick();
    tick();
    tick();
    in_vld = 2'b00;
    tick();
    tick();
    chk("sat_ffff", 64'(coll_cnt), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(coll_cnt), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
